// File: rtl/fft_pkg.sv
// Shared widths, RAM word layout and FSM states for the FFT result post-processing blocks.
package fft_pkg;

    localparam int unsigned FFT_OUTWIDTH   = 29;
    localparam int unsigned RAM_ADDR_WIDTH = 10;
    localparam int unsigned RAM_DATA_WIDTH = 64;
    localparam int unsigned FFTPTS_WIDTH   = 11;
    localparam int unsigned MAG_WIDTH      = 2 * FFT_OUTWIDTH + 1;
    localparam int unsigned PWR_WIDTH      = MAG_WIDTH + RAM_ADDR_WIDTH;

    // Result RAM word: real part in the upper half, imaginary in the lower half.
    localparam int unsigned RE_LSB = 32;
    localparam int unsigned IM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage |X|^2 pipeline: S1 squares re and im, S2 adds them.
// Ports: out_clk/rst; re, im, in_valid, in_bin in; mag, mag_valid, mag_bin out
// (mag_valid/mag_bin are in_valid/in_bin delayed to line up with mag).
module fft_mag_sq #(
    parameter int unsigned IN_WIDTH  = 29,
    parameter int unsigned BIN_WIDTH = 10
) (
    input  logic                          out_clk,
    input  logic                          rst,
    input  logic signed [IN_WIDTH-1:0]    re,
    input  logic signed [IN_WIDTH-1:0]    im,
    input  logic                          in_valid,
    input  logic        [BIN_WIDTH-1:0]   in_bin,
    output logic        [2*IN_WIDTH:0]    mag,
    output logic                          mag_valid,
    output logic        [BIN_WIDTH-1:0]   mag_bin
);

    localparam int unsigned SQ_WIDTH  = 2 * IN_WIDTH;
    localparam int unsigned MAG_WIDTH = SQ_WIDTH + 1;

    logic signed [SQ_WIDTH-1:0]  re_sq_c;
    logic signed [SQ_WIDTH-1:0]  im_sq_c;
    logic        [SQ_WIDTH-1:0]  re_sq_q;
    logic        [SQ_WIDTH-1:0]  im_sq_q;
    logic                        s1_valid_q;
    logic        [BIN_WIDTH-1:0] s1_bin_q;

    // A square is never negative, so the signed product can be kept unsigned.
    assign re_sq_c = SQ_WIDTH'(re) * SQ_WIDTH'(re);
    assign im_sq_c = SQ_WIDTH'(im) * SQ_WIDTH'(im);

    // S1: squares
    always_ff @(posedge out_clk or posedge rst) begin
        if (rst) begin
            re_sq_q    <= '0;
            im_sq_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_bin_q   <= '0;
        end else begin
            re_sq_q    <= $unsigned(re_sq_c);
            im_sq_q    <= $unsigned(im_sq_c);
            s1_valid_q <= in_valid;
            s1_bin_q   <= in_bin;
        end
    end

    // S2: sum, one extra bit so (-2^(W-1))^2 * 2 fits
    always_ff @(posedge out_clk or posedge rst) begin
        if (rst) begin
            mag       <= '0;
            mag_valid <= 1'b0;
            mag_bin   <= '0;
        end else begin
            mag       <= MAG_WIDTH'(re_sq_q) + MAG_WIDTH'(im_sq_q);
            mag_valid <= s1_valid_q;
            mag_bin   <= s1_bin_q;
        end
    end

endmodule

// File: rtl/fft_peak_search.sv
// Walks a bin window of the FFT result RAM, reporting peak |X|^2 bin/value and total window power.
// Ports: out_clk/rst; start + fftpts_in/bin_lo/bin_hi window request; ram_rd_addr/ram_rd_data
// result RAM read port; busy/done status; peak_bin, peak_mag, total_pwr results (held until next done).
module fft_peak_search #(
    parameter  int unsigned RAM_ADDR_WIDTH = fft_pkg::RAM_ADDR_WIDTH,
    parameter  int unsigned RAM_DATA_WIDTH = fft_pkg::RAM_DATA_WIDTH,
    parameter  int unsigned FFT_OUTWIDTH   = fft_pkg::FFT_OUTWIDTH,
    parameter  int unsigned FFTPTS_WIDTH   = fft_pkg::FFTPTS_WIDTH,
    parameter  int unsigned RAM_RD_LATENCY = 2,
    localparam int unsigned MAG_WIDTH      = 2 * FFT_OUTWIDTH + 1,
    localparam int unsigned PWR_WIDTH      = MAG_WIDTH + RAM_ADDR_WIDTH
) (
    input  logic                      out_clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [FFTPTS_WIDTH-1:0]   fftpts_in,
    input  logic [RAM_ADDR_WIDTH-1:0] bin_lo,
    input  logic [RAM_ADDR_WIDTH-1:0] bin_hi,
    output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [RAM_DATA_WIDTH-1:0] ram_rd_data,
    output logic                      busy,
    output logic                      done,
    output logic [RAM_ADDR_WIDTH-1:0] peak_bin,
    output logic [MAG_WIDTH-1:0]      peak_mag,
    output logic [PWR_WIDTH-1:0]      total_pwr
);

    import fft_pkg::*;

    state_t                      state_q, state_nx;
    logic [RAM_ADDR_WIDTH-1:0]   addr_nx, hi_q, hi_nx, hi_c;
    logic [FFTPTS_WIDTH-1:0]     pts_m1_c;
    logic                        empty_c;
    logic                        busy_nx, done_nx;
    logic [RAM_ADDR_WIDTH-1:0]   peak_bin_nx;
    logic [MAG_WIDTH-1:0]        peak_mag_nx;
    logic [PWR_WIDTH-1:0]        total_pwr_nx;

    // Address-valid pipe matching the RAM read latency
    logic [RAM_RD_LATENCY-1:0]   avld_q;
    logic [RAM_ADDR_WIDTH-1:0]   abin_q [RAM_RD_LATENCY];
    logic                        s1_vld_q;

    logic signed [FFT_OUTWIDTH-1:0] re_c, im_c;
    logic [MAG_WIDTH-1:0]        mag;
    logic                        mag_vld;
    logic [RAM_ADDR_WIDTH-1:0]   mag_bin;

    // S3 running results
    logic [MAG_WIDTH-1:0]        run_max_q, run_max_nx;
    logic [RAM_ADDR_WIDTH-1:0]   run_bin_q, run_bin_nx;
    logic [PWR_WIDTH-1:0]        run_pwr_q, run_pwr_nx;
    logic                        first_q, first_nx;

    logic                        unused_bits;

    assign re_c = $signed(ram_rd_data[RE_LSB +: FFT_OUTWIDTH]);
    assign im_c = $signed(ram_rd_data[IM_LSB +: FFT_OUTWIDTH]);
    assign unused_bits = ^{ram_rd_data[RAM_DATA_WIDTH-1:RE_LSB+FFT_OUTWIDTH],
                           ram_rd_data[RE_LSB-1:IM_LSB+FFT_OUTWIDTH]};

    // Effective window: clamp hi to the last FFT point
    assign pts_m1_c = fftpts_in - FFTPTS_WIDTH'(1);
    assign hi_c     = (FFTPTS_WIDTH'(bin_hi) > pts_m1_c) ? RAM_ADDR_WIDTH'(pts_m1_c) : bin_hi;
    assign empty_c  = (fftpts_in == '0) || (bin_lo > hi_c);

    fft_mag_sq #(
        .IN_WIDTH  (FFT_OUTWIDTH),
        .BIN_WIDTH (RAM_ADDR_WIDTH)
    ) u_mag_sq (
        .out_clk   (out_clk),
        .rst       (rst),
        .re        (re_c),
        .im        (im_c),
        .in_valid  (avld_q[RAM_RD_LATENCY-1]),
        .in_bin    (abin_q[RAM_RD_LATENCY-1]),
        .mag       (mag),
        .mag_valid (mag_vld),
        .mag_bin   (mag_bin)
    );

    // S3: accumulate; strict compare keeps the lowest bin on ties
    always_comb begin
        run_max_nx = run_max_q;
        run_bin_nx = run_bin_q;
        run_pwr_nx = run_pwr_q;
        first_nx   = first_q;
        if (state_q == IDLE && start) begin
            run_max_nx = '0;
            run_bin_nx = '0;
            run_pwr_nx = '0;
            first_nx   = 1'b1;
        end else if (mag_vld) begin
            run_pwr_nx = run_pwr_q + PWR_WIDTH'(mag);
            if (first_q || (mag > run_max_q)) begin
                run_max_nx = mag;
                run_bin_nx = mag_bin;
            end
            first_nx = 1'b0;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_nx     = state_q;
        addr_nx      = ram_rd_addr;
        hi_nx        = hi_q;
        peak_bin_nx  = peak_bin;
        peak_mag_nx  = peak_mag;
        total_pwr_nx = total_pwr;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (empty_c) begin
                        state_nx     = DONE;
                        peak_bin_nx  = bin_lo;
                        peak_mag_nx  = '0;
                        total_pwr_nx = '0;
                    end else begin
                        state_nx = READ;
                        addr_nx  = bin_lo;
                        hi_nx    = hi_c;
                    end
                end
            end
            READ: begin
                if (ram_rd_addr == hi_q) state_nx = DRAIN;
                else                     addr_nx  = ram_rd_addr + RAM_ADDR_WIDTH'(1);
            end
            DRAIN: begin
                // Last S2 result, if any, is folded in on this same edge via run_*_nx.
                if (avld_q == '0 && !s1_vld_q) begin
                    state_nx     = DONE;
                    peak_bin_nx  = run_bin_nx;
                    peak_mag_nx  = run_max_nx;
                    total_pwr_nx = run_pwr_nx;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == READ) || (state_nx == DRAIN);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge out_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_rd_addr <= '0;
            hi_q        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            peak_bin    <= '0;
            peak_mag    <= '0;
            total_pwr   <= '0;
            avld_q      <= '0;
            for (int i = 0; i < RAM_RD_LATENCY; i++) abin_q[i] <= '0;
            s1_vld_q    <= 1'b0;
            run_max_q   <= '0;
            run_bin_q   <= '0;
            run_pwr_q   <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_nx;
            ram_rd_addr <= addr_nx;
            hi_q        <= hi_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            peak_bin    <= peak_bin_nx;
            peak_mag    <= peak_mag_nx;
            total_pwr   <= total_pwr_nx;
            avld_q[0]   <= (state_q == READ);
            abin_q[0]   <= ram_rd_addr;
            for (int i = 1; i < RAM_RD_LATENCY; i++) begin
                avld_q[i] <= avld_q[i-1];
                abin_q[i] <= abin_q[i-1];
            end
            s1_vld_q    <= avld_q[RAM_RD_LATENCY-1];
            run_max_q   <= run_max_nx;
            run_bin_q   <= run_bin_nx;
            run_pwr_q   <= run_pwr_nx;
            first_q     <= first_nx;
        end
    end

endmodule

// File: doc/fft_peak_search.md
Name: fft_peak_search

Overview:
- Sits directly downstream of the FFT control block on the `out_clk` domain.
- After an FFT frame is written to the result RAM, it walks a programmable bin window through the RAM read port and computes |X|² = re² + im² per bin.
- Reports the peak bin, the peak magnitude-squared and the total in-window power for the NMR echo spectrum.
- Single clock, no CDC.

Parameters:
- `RAM_ADDR_WIDTH`, 10, result RAM address width.
- `RAM_DATA_WIDTH`, 64, RAM word: [63:32] = real, [31:0] = imag, each sign-extended two's complement.
- `FFT_OUTWIDTH`, 29, significant signed bits of each of re/im.
- `FFTPTS_WIDTH`, 11, width of the FFT point count.
- `RAM_RD_LATENCY`, 2, cycles from `ram_rd_addr` change to valid `ram_rd_data`; legal range 1..4.
- `MAG_WIDTH`, 2*FFT_OUTWIDTH+1 = 59, localparam, magnitude-squared width.
- `PWR_WIDTH`, MAG_WIDTH+RAM_ADDR_WIDTH = 69, localparam, accumulator width.

Ports:
- `out_clk`  in  1  block clock (FFT output clock domain).
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a search.
- `fftpts_in`  in  FFTPTS_WIDTH  FFT points in the current frame.
- `bin_lo`  in  RAM_ADDR_WIDTH  first bin of the window, inclusive.
- `bin_hi`  in  RAM_ADDR_WIDTH  last bin of the window, inclusive.
- `ram_rd_addr`  out  RAM_ADDR_WIDTH  result RAM read address.
- `ram_rd_data`  in  RAM_DATA_WIDTH  result RAM read data.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; results are valid from this cycle.
- `peak_bin`  out  RAM_ADDR_WIDTH  bin index of the maximum |X|².
- `peak_mag`  out  MAG_WIDTH  maximum |X|², unsigned.
- `total_pwr`  out  PWR_WIDTH  sum of |X|² over the window, unsigned.

Behaviour:
- Reset: every output is 0, state = IDLE, all pipeline valids cleared. Reset is honoured in any state; an in-flight search is abandoned and no `done` is issued.
- `start` and window inputs are sampled together on the `start` cycle. `start` while `busy` or `done` is high is ignored.
- Effective window, computed at `start`:
  - lo = `bin_lo`.
  - hi = min(`bin_hi`, `fftpts_in`-1).
  - `fftpts_in` = 0, or lo > hi, gives an empty window.
- State machine:
  - IDLE: on `start` with an empty window, go to DONE with `peak_bin` = lo, `peak_mag` = 0, `total_pwr` = 0. Otherwise set `ram_rd_addr` = lo and go to READ.
  - READ: one address per cycle. `ram_rd_addr` increments every cycle; on `ram_rd_addr` == hi, go to DRAIN. Each issued address pushes a valid bit and its bin index into a RAM_RD_LATENCY-deep shift register.
  - DRAIN: wait until the address valid pipe and the magnitude pipe are both empty, then go to DONE.
  - DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `ram_rd_addr` holds its last value in IDLE, DRAIN and DONE.
- Arithmetic pipeline, 3 stages after data arrival:
  - S1: re = `ram_rd_data`[32+FFT_OUTWIDTH-1:32], im = `ram_rd_data`[FFT_OUTWIDTH-1:0], both signed. Register re*re and im*im (2*FFT_OUTWIDTH bits each, unsigned).
  - S2: register the sum (MAG_WIDTH bits; no overflow possible).
  - S3: update the running results. `total_pwr` += sum. If the sum is strictly greater than the running max, replace max and bin. Ties keep the lowest bin. The first bin of the window always loads.
- The running max, bin and power are internal registers, cleared at `start`.
- `peak_bin`, `peak_mag` and `total_pwr` update only on the `done` cycle and hold until the next `done` or reset.
- Latency: a non-empty window of N bins gives `done` exactly N + RAM_RD_LATENCY + 3 cycles after the `start` cycle. An empty window gives `done` 1 cycle after `start`.
- `busy` goes to 0 in the same cycle that `done` = 1.
- No address wrap: hi ≤ 2^RAM_ADDR_WIDTH-1, so the increment never passes hi. `bin_hi` = 1023 with `fftpts_in` = 1024 is legal.

Decomposition:
- Shared package `fft_pkg`:
  - width constants FFT_OUTWIDTH, RAM_ADDR_WIDTH, RAM_DATA_WIDTH, MAG_WIDTH, PWR_WIDTH.
  - RAM word field offsets RE_LSB = 32, IM_LSB = 0.
  - state enum {IDLE, READ, DRAIN, DONE}.
- Sub-module `fft_mag_sq`: the 2-stage squarer/adder (S1–S2).
  - Inputs: re, im, valid, bin.
  - Outputs: mag, valid, bin.
  - Isolates multiplier inference and DSP-block mapping.

Test Plan:
- Bench setup: behavioural RAM model with latency 2, 1024 entries.
- Single tone: bin 100 = (re 1000, im −2000), all others 0; `fftpts_in` = 1024, window 0..1023 → `peak_bin` = 100, `peak_mag` = 5,000,000, `total_pwr` = 5,000,000; `done` 1029 cycles after `start`.
- Tie and extremes: bins 10 and 20 = (−2^28, −2^28), all others (1,1); window 0..1023 → `peak_bin` = 10, `peak_mag` = 2^57, `total_pwr` = 2^58 + 2044.
- Clamp and empty windows:
  - `fftpts_in` = 256, window 200..900 → reads stop at address 255, 56 bins summed.
  - Window 50..40 → `done` 1 cycle after `start`, `peak_bin` = 50, `peak_mag` = 0, `total_pwr` = 0.
- Protocol: second `start` pulse 5 cycles into a search → ignored; results match the first window only; `busy` is continuous.
- Reset mid-search: assert `rst` at cycle 300 of a 1024-bin search → all outputs 0 immediately, no `done`. A new search after release gives correct results.
